fp_sign_pipe: RTL

//  Parametrised, pipelined sign-manipulation unit for the custom float format
//  {sign, exponent[EXP_W], mantissa[MAN_W]}. Generalises plain negation to four

---
 rtl/fp_sign_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/fp_sign_pipe.sv
// Two-stage valid/ready pipeline that rewrites the sign bit of a custom float word.
// Modes: pass, negate, absolute value, copysign(a, b); exponent and mantissa always come from a.
module fp_sign_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 18,
    parameter int TAG_W = 4,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_COPY = 2'b11;

    // Only the sign of b is ever consulted, so S1 keeps just that bit.
    logic unused_b_mag;
    assign unused_b_mag = ^in_b[W-2:0];

    logic             s1_v_q, s1_v_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic             s1_bs_q, s1_bs_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_v_q, s2_v_d;
    logic [W-1:0]     s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_zero_q, s2_zero_d;

    logic             adv1, adv2;
    logic             res_sign;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        adv2      = !s2_v_q || out_ready;
        adv1      = !s1_v_q || adv2;

        s1_v_d    = adv1 ? in_valid : s1_v_q;
        s1_a_d    = s1_a_q;
        s1_bs_d   = s1_bs_q;
        s1_mode_d = s1_mode_q;
        s1_tag_d  = s1_tag_q;
        if (adv1 && in_valid) begin
            s1_a_d    = in_a;
            s1_bs_d   = in_b[W-1];
            s1_mode_d = in_mode;
            s1_tag_d  = in_tag;
        end

        res_sign = s1_a_q[W-1];
        case (s1_mode_q)
            MODE_PASS: res_sign = s1_a_q[W-1];
            MODE_NEG:  res_sign = ~s1_a_q[W-1];
            MODE_ABS:  res_sign = 1'b0;
            MODE_COPY: res_sign = s1_bs_q;
            default:   res_sign = s1_a_q[W-1];
        endcase

        s2_v_d    = adv2 ? s1_v_q : s2_v_q;
        s2_res_d  = s2_res_q;
        s2_tag_d  = s2_tag_q;
        s2_zero_d = s2_zero_q;
        if (adv2 && s1_v_q) begin
            s2_res_d  = {res_sign, s1_a_q[W-2:0]};
            s2_tag_d  = s1_tag_q;
            s2_zero_d = (s1_a_q[W-2:0] == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_res_q  <= '0;
            s2_tag_q  <= '0;
            s2_zero_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s2_res_q  <= s2_res_d;
            s2_tag_q  <= s2_tag_d;
            s2_zero_q <= s2_zero_d;
        end
    end

    // NOTE: S1 payload is left unreset; it is only ever read while s1_v_q qualifies it.
    always_ff @(posedge clk) begin
        s1_a_q    <= s1_a_d;
        s1_bs_q   <= s1_bs_d;
        s1_mode_q <= s1_mode_d;
        s1_tag_q  <= s1_tag_d;
    end

    assign in_ready  = adv1;
    assign out_valid = s2_v_q;
    assign out_res   = s2_res_q;
    assign out_tag   = s2_tag_q;
    assign out_zero  = s2_zero_q;

endmodule
